// File: rtl/secuencia_pkg.sv
// Shared definitions for the serializer/detector pair: FSM encoding, detection pattern, counter sizing.
// Pure declarations, no timing and no flow control of its own.
package secuencia_pkg;

    typedef enum logic [0:0] {
        REPOSO    = 1'b0,
        TRANSMITE = 1'b1
    } estado_t;

    localparam logic [3:0] PATRON = 4'b1101;

    // Counter width for a modulo-n count, never narrower than one bit.
    function automatic int ancho_cont(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serializador_secuencia_if.sv
// Parallel-word handshake into the serializer; a transfer is palabra_valida & palabra_lista at a rising edge.
// The source holds palabra stable while palabra_valida is high.
interface serializador_secuencia_if #(parameter int ANCHO = 8);

    logic [ANCHO-1:0] palabra;
    logic             palabra_valida;
    logic             palabra_lista;

    modport master (output palabra, output palabra_valida, input palabra_lista);
    modport slave  (input palabra, input palabra_valida, output palabra_lista);

endinterface

// File: rtl/serializador_secuencia_divisor_bit.sv
// Bit-period divider: counts 0..CICLOS_BIT-1 while enabled; tick marks the last clock of a period.
// tick is combinational from the count; tick_prox is its value after the coming edge. No backpressure.
module divisor_bit
    import secuencia_pkg::*;
#(
    parameter int CICLOS_BIT = 2
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    output logic tick,
    output logic tick_prox
);

    localparam int              W      = ancho_cont(CICLOS_BIT);
    localparam logic [W-1:0]    ULTIMO = W'(CICLOS_BIT - 1);

    logic [W-1:0] cont;
    logic [W-1:0] cont_prox;

    always_comb begin
        cont_prox = cont;
        if (clear) begin
            cont_prox = '0;
        end else if (en) begin
            cont_prox = (cont == ULTIMO) ? '0 : cont + 1'b1;
        end
    end

    assign tick      = (cont == ULTIMO);
    assign tick_prox = (cont_prox == ULTIMO);

    always_ff @(posedge clk) begin
        cont <= cont_prox;
    end

endmodule

// File: rtl/serializador_secuencia.sv
// MSB-first serializer with a one-word holding buffer; first bit on dato 1 clock after the accepting edge.
// palabra_lista drops while the buffer is full; a word offered in the last clock of a word bypasses to the line.
module serializador_secuencia
    import secuencia_pkg::*;
#(
    parameter int ANCHO      = 8,
    parameter int CICLOS_BIT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    serializador_secuencia_if.slave  ent,
    output logic                     dato,
    output logic                     dato_valido,
    output logic                     ocupado,
    output logic                     fin_palabra
);

    if (ANCHO < 2) begin : g_chk_ancho
        $error("serializador_secuencia: ANCHO must be >= 2");
    end
    if (CICLOS_BIT < 1) begin : g_chk_ciclos
        $error("serializador_secuencia: CICLOS_BIT must be >= 1");
    end

    localparam int               WB         = ancho_cont(ANCHO);
    localparam logic [WB-1:0]    ULTIMO_BIT = WB'(ANCHO - 1);

    estado_t          estado;
    logic [ANCHO-1:0] desplaza;
    logic [ANCHO-1:0] buffer;
    logic             buffer_lleno;
    logic [WB-1:0]    cont_bit;
    logic [WB-1:0]    cont_bit_sig;
    logic             tick;
    logic             tick_prox;
    logic             transfer;
    logic             ultimo_ciclo;

    divisor_bit #(.CICLOS_BIT(CICLOS_BIT)) u_divisor (
        .clk       (clk),
        .clear     (reset),
        .en        (estado == TRANSMITE),
        .tick      (tick),
        .tick_prox (tick_prox)
    );

    assign ent.palabra_lista = ~reset & ~buffer_lleno;
    assign transfer          = ent.palabra_valida & ent.palabra_lista;
    assign ultimo_ciclo      = tick && (cont_bit == ULTIMO_BIT);
    assign cont_bit_sig      = tick ? cont_bit + 1'b1 : cont_bit;

    // The shift register is zeroed whenever the line is idle, so its MSB doubles as the registered dato.
    assign dato = desplaza[ANCHO-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= REPOSO;
            desplaza     <= '0;
            buffer       <= '0;
            buffer_lleno <= 1'b0;
            cont_bit     <= '0;
            dato_valido  <= 1'b0;
            ocupado      <= 1'b0;
            fin_palabra  <= 1'b0;
        end else begin
            fin_palabra <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (transfer) begin
                        estado      <= TRANSMITE;
                        desplaza    <= ent.palabra;
                        cont_bit    <= '0;
                        dato_valido <= 1'b1;
                        ocupado     <= 1'b1;
                    end
                end
                TRANSMITE: begin
                    if (ultimo_ciclo) begin
                        cont_bit <= '0;
                        if (buffer_lleno) begin
                            desplaza     <= buffer;
                            buffer_lleno <= 1'b0;
                        end else if (transfer) begin
                            desplaza <= ent.palabra;
                        end else begin
                            estado      <= REPOSO;
                            desplaza    <= '0;
                            dato_valido <= 1'b0;
                            ocupado     <= 1'b0;
                        end
                    end else begin
                        if (tick) begin
                            cont_bit <= cont_bit_sig;
                            desplaza <= {desplaza[ANCHO-2:0], 1'b0};
                        end
                        if (transfer) begin
                            buffer       <= ent.palabra;
                            buffer_lleno <= 1'b1;
                        end
                        // Look one clock ahead so the pulse is registered yet lands in the last clock.
                        fin_palabra <= tick_prox && (cont_bit_sig == ULTIMO_BIT);
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule
